router_1xn: RTL

Parametrised single-input, N-output packet router: the next generation of the 1x3 router, generalised in data width, FIFO depth, port count and timeout. A byte-serial packet source is demultiplexed by header address into per-port FIFOs, with parity checking and explicit `busy` backpressure. New behaviour: invalid-address packets are dropped and counted, and a timeout flush aborts an in-flight packet cleanly.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_port_fifo.sv | 77 +++++++
 rtl/router_1xn.sv | 133 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN packet router.
package router_pkg;

  typedef enum logic [1:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD,
    DROP
  } state_t;

  localparam int DROP_W = 8;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/router_port_fifo.sv
// One output port: FIFO with registered read data,
// plus an unread-timeout counter that flushes the port.
module router_port_fifo #(
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic          flush,
  output logic [DW-1:0] rd_data
);

  localparam int AD = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [AD:0]    wptr_q, wptr_d;
  logic [AD:0]    rptr_q, rptr_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic           do_wr, do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AD] != rptr_q[AD]) &&
                 (wptr_q[AD-1:0] == rptr_q[AD-1:0]);
  assign flush = (cnt_q == TW'(TIMEOUT - 1)) &&
                 !empty && !rd_en;
  // a flush beats a same-cycle write
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty;
  assign rd_data = dout_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      dout_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (do_rd) begin
        rptr_d = rptr_q + 1'b1;
        dout_d = mem_q[rptr_q[AD-1:0]];
      end
      cnt_d = (rd_en || empty) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AD-1:0]] <= wr_data;
  end

endmodule

// File: rtl/router_1xn.sv
// 1xN byte-serial packet router: header decode, parity,
// drop of bad addresses and timeout-aborted packets.
module router_1xn
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int N_PORTS = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pkt_valid,
  input  logic [DW-1:0]         data_in,
  output logic                  busy,
  output logic                  error,
  output logic [DROP_W-1:0]     drop_cnt,
  input  logic [N_PORTS-1:0]    read_en,
  output logic [N_PORTS-1:0]    vld_out,
  output logic [N_PORTS*DW-1:0] data_out
);

  localparam int AW = addr_w(N_PORTS);

  state_t              state_q, state_d;
  logic [DW-1:0]       hdr_q, hdr_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       tgt_q, tgt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                err_q, err_d;
  logic [AW-1:0]       addr;
  logic                addr_ok;
  logic [N_PORTS-1:0]  wr_en, full, empty, flush;
  logic [DW-1:0]       wr_data;

  assign addr     = data_in[AW-1:0];
  assign addr_ok  = int'(addr) < N_PORTS;
  assign vld_out  = ~empty;
  assign error    = err_q;
  assign drop_cnt = drop_q;

  always_comb begin
    unique case (state_q)
      WAIT_EMPTY: busy = 1'b1;
      LOAD:       busy = full[tgt_q];
      default:    busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    acc_d   = acc_q;
    tgt_d   = tgt_q;
    drop_d  = drop_q;
    err_d   = 1'b0;
    wr_en   = '0;
    wr_data = data_in;
    unique case (state_q)
      DECODE: if (pkt_valid) begin
        hdr_d = data_in;
        acc_d = data_in;
        tgt_d = addr;
        if (!addr_ok) begin
          drop_d  = sat_inc(drop_q);
          state_d = DROP;
        end else if (empty[addr]) begin
          wr_en[addr] = 1'b1;
          state_d     = LOAD;
        end else begin
          state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: if (empty[tgt_q]) begin
        wr_en[tgt_q] = 1'b1;
        wr_data      = hdr_q;
        state_d      = LOAD;
      end
      LOAD: if (flush[tgt_q]) begin
        // aborted packet; an accepted parity byte ends it here
        drop_d  = sat_inc(drop_q);
        state_d = (!full[tgt_q] && !pkt_valid) ? DECODE : DROP;
      end else if (!full[tgt_q]) begin
        wr_en[tgt_q] = 1'b1;
        if (pkt_valid) begin
          acc_d = acc_q ^ data_in;
        end else begin
          err_d   = (acc_q != data_in);
          state_d = DECODE;
        end
      end
      DROP: if (!pkt_valid) state_d = DECODE;
      default: state_d = DECODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= DECODE;
      hdr_q   <= '0;
      acc_q   <= '0;
      tgt_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      acc_q   <= acc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    router_port_fifo #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en[k]),
      .wr_data (wr_data),
      .rd_en   (read_en[k]),
      .full    (full[k]),
      .empty   (empty[k]),
      .flush   (flush[k]),
      .rd_data (data_out[k*DW +: DW])
    );
  end

endmodule
